// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) CIC decimator with run-time ratio and gain shift,
// post-ratio-change priming, round-half-up rescaling and saturation.
module cic_decim_iq #(
    parameter  int IN_W       = 16,
    parameter  int OUT_W      = 16,
    parameter  int STAGES     = 5,
    parameter  int MAX_LOG2_R = 14,
    localparam int ACC_W      = IN_W + STAGES * MAX_LOG2_R,
    localparam int SHIFT_W    = $clog2(ACC_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_i,
    input  logic [IN_W-1:0]    in_q,
    input  logic [15:0]        rate,
    input  logic [SHIFT_W-1:0] gain_shift,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_i,
    output logic [OUT_W-1:0]   out_q,
    output logic               out_sat
);

    localparam int STG_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int PRIME_W = $clog2(STAGES + 1);
    localparam int RM1_W   = MAX_LOG2_R;

    localparam logic [31:0]          MIN_R     = 32'(STAGES + 2);
    localparam logic [31:0]          MAX_R     = 32'(1) << MAX_LOG2_R;
    localparam logic [SHIFT_W-1:0]   SHIFT_MAX = SHIFT_W'(ACC_W - OUT_W);
    localparam logic [PRIME_W-1:0]   PRIME_N   = PRIME_W'(STAGES);
    localparam logic signed [ACC_W:0] OUT_MAX  = $signed({{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] OUT_MIN  = $signed({{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
    localparam logic [OUT_W-1:0]     SAT_HI    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     SAT_LO    = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COMB, S_SCALE, S_OUT} state_t;

    typedef struct packed {
        logic [OUT_W-1:0] val;
        logic             sat;
    } scaled_t;

    // Effective ratio is stored as R_eff-1 so it fits MAX_LOG2_R bits.
    function automatic logic [RM1_W-1:0] clamp_rm1(input logic [15:0] r);
        logic [31:0] rv;
        rv = {16'b0, r};
        if (rv < MIN_R)      rv = MIN_R;
        else if (rv > MAX_R) rv = MAX_R;
        rv = rv - 32'd1;
        return rv[RM1_W-1:0];
    endfunction

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

    // Round half up, arithmetic shift, saturate to OUT_W.
    function automatic scaled_t scale(input logic [ACC_W-1:0] c, input logic [SHIFT_W-1:0] sh);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] s;
        scaled_t               r;
        rnd = '0;
        if (sh != '0) rnd[sh - 1'b1] = 1'b1;
        v = $signed({c[ACC_W-1], c}) + rnd;
        s = v >>> sh;
        if (s > OUT_MAX) begin
            r.val = SAT_HI;
            r.sat = 1'b1;
        end else if (s < OUT_MIN) begin
            r.val = SAT_LO;
            r.sat = 1'b1;
        end else begin
            r.val = s[OUT_W-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic               cfg_loaded_q, cfg_loaded_d;
    logic [RM1_W-1:0]   rm1_q, rm1_d, cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic [ACC_W-1:0]   integ_q [2][STAGES];
    logic [ACC_W-1:0]   integ_d [2][STAGES];
    logic [ACC_W-1:0]   dly_q   [2][STAGES];
    logic [ACC_W-1:0]   dly_d   [2][STAGES];
    logic [ACC_W-1:0]   comb_x_q [2];
    logic [ACC_W-1:0]   comb_x_d [2];
    logic [OUT_W-1:0]   scl_q [2];
    logic [OUT_W-1:0]   scl_d [2];
    logic [OUT_W-1:0]   res_q [2];
    logic [OUT_W-1:0]   res_d [2];
    logic               scl_sat_q, scl_sat_d;
    logic               out_sat_q, out_sat_d;
    logic               out_valid_q, out_valid_d;

    logic [IN_W-1:0]    in_ch [2];
    logic [RM1_W-1:0]   rm1_new, rm1_cur;
    logic [SHIFT_W-1:0] shift_new;
    logic               wrap;
    logic [ACC_W-1:0]   acc;
    scaled_t            sc;

    assign in_ch[0]  = in_i;
    assign in_ch[1]  = in_q;
    assign rm1_new   = clamp_rm1(rate);
    assign shift_new = clamp_shift(gain_shift);
    // Before the first post-reset latch the live rate input is the ratio in force.
    assign rm1_cur   = cfg_loaded_q ? rm1_q : rm1_new;
    assign wrap      = in_valid && (cnt_q == rm1_cur);

    // Next-state logic: integrators, decimation counter, config latch, comb sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        stage_d      = stage_q;
        cfg_loaded_d = cfg_loaded_q;
        rm1_d        = rm1_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        prime_d      = prime_q;
        integ_d      = integ_q;
        dly_d        = dly_q;
        comb_x_d     = comb_x_q;
        scl_d        = scl_q;
        scl_sat_d    = scl_sat_q;
        res_d        = res_q;
        out_sat_d    = out_sat_q;
        out_valid_d  = 1'b0;
        acc          = '0;
        sc           = '0;

        if (!cfg_loaded_q) begin
            cfg_loaded_d = 1'b1;
            rm1_d        = rm1_new;
            shift_d      = shift_new;
        end

        if (in_valid) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                // NOTE: blocking '=' here is deliberate: acc carries each stage's new sum into the next stage.
                acc = {{(ACC_W-IN_W){in_ch[ch][IN_W-1]}}, in_ch[ch]};
                for (int k = 0; k < STAGES; k++) begin
                    acc              = integ_q[ch][k] + acc;
                    integ_d[ch][k]   = acc;
                end
            end
        end

        case (state_q)
            S_COMB: begin
                for (int ch = 0; ch < 2; ch++) begin
                    for (int k = 0; k < STAGES; k++) begin
                        if (stage_q == STG_W'(k)) begin
                            comb_x_d[ch] = comb_x_q[ch] - dly_q[ch][k];
                            dly_d[ch][k] = comb_x_q[ch];
                        end
                    end
                end
                stage_d = stage_q + 1'b1;
                if (stage_q == STG_W'(STAGES - 1)) state_d = S_SCALE;
            end
            S_SCALE: begin
                scl_sat_d = 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    sc        = scale(comb_x_q[ch], shift_q);
                    scl_d[ch] = sc.val;
                    scl_sat_d = scl_sat_d | sc.sat;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (prime_q != '0) begin
                    prime_d = prime_q - 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    res_d       = scl_q;
                    out_sat_d   = scl_sat_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A wrap may land on the OUT cycle at the minimum ratio; it starts the next pass.
        if (wrap) begin
            rm1_d   = rm1_new;
            shift_d = shift_new;
            if (rm1_new != rm1_cur) prime_d = PRIME_N;
            for (int ch = 0; ch < 2; ch++) comb_x_d[ch] = integ_d[ch][STAGES-1];
            state_d = S_COMB;
            stage_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: integrator and comb delay arrays are plain flops holding filter state, so they are cleared on reset.
            state_q      <= S_IDLE;
            stage_q      <= '0;
            cfg_loaded_q <= 1'b0;
            rm1_q        <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            prime_q      <= PRIME_N;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < STAGES; k++) begin
                    integ_q[ch][k] <= '0;
                    dly_q[ch][k]   <= '0;
                end
                comb_x_q[ch] <= '0;
                scl_q[ch]    <= '0;
                res_q[ch]    <= '0;
            end
            scl_sat_q    <= 1'b0;
            out_sat_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' so every flop samples pre-edge values.
            state_q      <= state_d;
            stage_q      <= stage_d;
            cfg_loaded_q <= cfg_loaded_d;
            rm1_q        <= rm1_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            prime_q      <= prime_d;
            integ_q      <= integ_d;
            dly_q        <= dly_d;
            comb_x_q     <= comb_x_d;
            scl_q        <= scl_d;
            res_q        <= res_d;
            scl_sat_q    <= scl_sat_d;
            out_sat_q    <= out_sat_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = res_q[0];
    assign out_q     = res_q[1];
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cic_decim_iq.sv
// Scoreboard bench for cic_decim_iq: the reference model computes each
// decimated output as the convolution of the accepted sample history with
// the (boxcar of length R)^STAGES impulse response, then rounds/saturates.
module tb_cic_decim_iq;

    localparam int IN_W       = 16;
    localparam int OUT_W      = 16;
    localparam int STAGES     = 5;
    localparam int MAX_LOG2_R = 14;
    localparam int ACC_W      = IN_W + STAGES * MAX_LOG2_R;
    localparam int SHIFT_W    = $clog2(ACC_W);
    localparam int LATENCY    = STAGES + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [IN_W-1:0]    in_i = '0;
    logic [IN_W-1:0]    in_q = '0;
    logic [15:0]        rate = 16'd16;
    logic [SHIFT_W-1:0] gain_shift = SHIFT_W'(20);
    logic               out_valid;
    logic [OUT_W-1:0]   out_i;
    logic [OUT_W-1:0]   out_q;
    logic               out_sat;

    cic_decim_iq #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .STAGES     (STAGES),
        .MAX_LOG2_R (MAX_LOG2_R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_i       (in_i),
        .in_q       (in_q),
        .rate       (rate),
        .gain_shift (gain_shift),
        .out_valid  (out_valid),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_sat    (out_sat)
    );

    typedef struct {
        longint due;
        int     i;
        int     q;
        bit     sat;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_err = 0;
    int     last_i = 0;
    int     last_q = 0;
    bit     last_sat = 1'b0;
    bit     mon_en = 1'b0;

    // Reference model state
    int     r_cur, sh_cur, prime_m, cnt_m;
    int     hist_i[$];
    int     hist_q[$];
    longint h[];
    int     h_r = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int clamp_r(input int r);
        if (r < STAGES + 2) return STAGES + 2;
        if (r > (1 << MAX_LOG2_R)) return 1 << MAX_LOG2_R;
        return r;
    endfunction

    function automatic int clamp_sh(input int s);
        return (s > ACC_W - OUT_W) ? ACC_W - OUT_W : s;
    endfunction

    function automatic int clip(input longint v, output bit s);
        s = 1'b1;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        s = 1'b0;
        return int'(v);
    endfunction

    // Impulse response of STAGES cascaded length-r moving sums.
    task automatic build_h(input int r);
        longint t[];
        h = new[1];
        h[0] = 1;
        for (int st = 0; st < STAGES; st++) begin
            t = new[h.size() + r - 1];
            foreach (t[i]) t[i] = 0;
            foreach (h[i]) for (int k = 0; k < r; k++) t[i+k] += h[i];
            h = t;
        end
        h_r = r;
    endtask

    task automatic model_pass(input longint due);
        longint ci, cq, rnd;
        int     n;
        bit     si, sq;
        exp_t   e;
        if (h_r != r_cur) build_h(r_cur);
        ci = 0;
        cq = 0;
        n  = hist_i.size() - 1;
        for (int j = 0; j < h.size(); j++) begin
            if (n - j >= 0) begin
                ci += h[j] * longint'(hist_i[n-j]);
                cq += h[j] * longint'(hist_q[n-j]);
            end
        end
        rnd   = (sh_cur > 0) ? (longint'(1) <<< (sh_cur - 1)) : 0;
        e.due = due;
        e.i   = clip((ci + rnd) >>> sh_cur, si);
        e.q   = clip((cq + rnd) >>> sh_cur, sq);
        e.sat = si | sq;
        exp_q.push_back(e);
    endtask

    task automatic model_wrap(input longint due);
        int nr, ns;
        nr = clamp_r(int'(rate));
        ns = clamp_sh(int'(gain_shift));
        if (nr != r_cur) prime_m = STAGES;
        r_cur  = nr;
        sh_cur = ns;
        if (prime_m > 0) prime_m--;
        else model_pass(due);
    endtask

    // Drive one cycle (called just after a posedge); the sample is taken at the next edge.
    task automatic step(input bit v, input int di, input int dq);
        in_valid = v;
        in_i     = IN_W'(di);
        in_q     = IN_W'(dq);
        if (v) begin
            hist_i.push_back(di);
            hist_q.push_back(dq);
            if (cnt_m == r_cur - 1) begin
                cnt_m = 0;
                model_wrap(cyc + 1 + LATENCY);
            end else begin
                cnt_m++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int r, input int gs);
        rate       = 16'(r);
        gain_shift = SHIFT_W'(gs);
        in_valid   = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hist_i.delete();
        hist_q.delete();
        last_i   = 0;
        last_q   = 0;
        last_sat = 1'b0;
        r_cur    = clamp_r(r);
        sh_cur   = clamp_sh(gs);
        prime_m  = STAGES;
        cnt_m    = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_i", $signed(out_i), 0);
        check("rst_out_q", $signed(out_q), 0);
        check("rst_out_sat", out_sat, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Monitor: pops the scoreboard on each out_valid, checks hold between strobes.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_valid_time", cyc, e.due);
                    check("out_i", $signed(out_i), e.i);
                    check("out_q", $signed(out_q), e.q);
                    check("out_sat", out_sat, e.sat);
                    last_i   = e.i;
                    last_q   = e.q;
                    last_sat = e.sat;
                end
            end else begin
                check("hold_out_i", $signed(out_i), last_i);
                check("hold_out_q", $signed(out_q), last_q);
                check("hold_out_sat", out_sat, last_sat);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("missing_out_valid", out_valid, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        mon_en = 1'b1;

        // DC, continuous, R=16, unity gain
        do_reset(16, 20);
        repeat (16 * 8) step(1, 1000, -1000);

        // DC, one accepted sample every third cycle
        do_reset(16, 20);
        for (int k = 0; k < 16 * 8; k++) begin
            step(1, 1000, -1000);
            step(0, 0, 0);
            step(0, 0, 0);
        end

        // Random data, gain shift changed mid-frame (no re-prime)
        do_reset(16, 20);
        repeat (16 * 7 + 5) step(1, rnd16(), rnd16());
        gain_shift = SHIFT_W'(21);
        repeat (16 * 4) step(1, rnd16(), rnd16());

        // Ratio below the minimum clamps to STAGES+2, random data
        do_reset(3, 14);
        repeat (7 * 15) step(1, rnd16(), rnd16());

        // Saturation both directions
        do_reset(16, 19);
        repeat (16 * 8) step(1, 20000, -20000);

        // Ratio 16 -> 32 and shift 20 -> 25 mid-frame
        do_reset(16, 20);
        repeat (16 * 7 + 8) step(1, 1000, -1000);
        rate       = 16'd32;
        gain_shift = SHIFT_W'(25);
        repeat (8 + 32 * 7) step(1, 1000, -1000);

        // Reset one cycle into COMB aborts the pass and restarts priming
        do_reset(16, 20);
        repeat (16 * 8) step(1, 1000, -1000);
        do_reset(16, 20);
        repeat (16 * 7) step(1, 1000, -1000);

        // Maximum ratio: first wrap only after 16384 samples, then R=7
        do_reset(16'hFFFF, 14);
        repeat (100) step(1, 1000, -1000);
        rate = 16'd3;
        repeat ((1 << MAX_LOG2_R) - 100 + 7 * 7) step(1, 1000, -1000);

        repeat (20) step(0, 0, 0);
        check("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
